// File: rtl/cl_ddb_pkg.sv
// Shared definitions for the DDB cfg_bus slave: register map, field positions and generator constants.
package cl_ddb_pkg;

  localparam logic [7:0] DDB_OFS_CTRL    = 8'h00;
  localparam logic [7:0] DDB_OFS_STATUS  = 8'h04;
  localparam logic [7:0] DDB_OFS_DATA    = 8'h08;
  localparam logic [7:0] DDB_OFS_SEED    = 8'h0C;
  localparam logic [7:0] DDB_OFS_GEN_CNT = 8'h10;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_CLR_BIT     = 1;
  localparam int CTRL_UNF_CLR_BIT = 2;
  localparam int CTRL_THR_LSB     = 8;
  localparam int CTRL_THR_MSB     = 15;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_UNF_BIT   = 31;

  localparam logic [31:0] DDB_DEADBEEF   = 32'hdead_beef;
  // Galois form of x^32+x^22+x^2+x+1, right-shifting.
  localparam logic [31:0] DDB_LFSR_TAPS  = 32'h8020_0003;

  function automatic logic [31:0] ddb_lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? DDB_LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/ddb_sync_fifo.sv
// Single-clock FIFO with flush; head word is read straight from the registered storage.
module ddb_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cl_ddb_cfg_slv.sv
// cfg_bus slave for the DDB data generator: register decode, 1-clk ack, generator feeding a FIFO.
// Build option DDB_LFSR_EN selects a 32-bit Galois LFSR generator instead of the +1 counter.
module cl_ddb_cfg_slv
  import cl_ddb_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] GEN_INIT   = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        flr_assert_q,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  output logic        ddb_irq_lvl
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef DDB_LFSR_EN
  function automatic logic [31:0] gen_step(input logic [31:0] g);
    return ddb_lfsr_step(g);
  endfunction
  // An all-zero LFSR state would lock up.
  function automatic logic [31:0] gen_load(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction
`else
  function automatic logic [31:0] gen_step(input logic [31:0] g);
    return g + 32'd1;
  endfunction
  function automatic logic [31:0] gen_load(input logic [31:0] s);
    return s;
  endfunction
`endif

  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic [7:0]  thresh_q, thresh_d;
  logic [31:0] seed_q, seed_d;
  logic        unf_q, unf_d;
  logic [31:0] gen_q, gen_d;
  logic [31:0] gen_cnt_q, gen_cnt_d;

  logic [7:0]    ofs;
  logic          wr_acc, rd_acc, ctrl_wr, seed_wr, data_rd;
  logic          push, pop, flush;
  logic [31:0]   fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   count16;
  logic [31:0]   status;
  logic          unused_addr;

  assign ofs         = cfg_addr[7:0];
  assign unused_addr = ^cfg_addr[31:8];

  // FLR idles the upstream state machine, so pulses seen during it are dropped.
  assign wr_acc  = cfg_wr & ~flr_assert_q;
  assign rd_acc  = cfg_rd & ~cfg_wr & ~flr_assert_q;
  assign ctrl_wr = wr_acc && (ofs == DDB_OFS_CTRL);
  assign seed_wr = wr_acc && (ofs == DDB_OFS_SEED);
  assign data_rd = rd_acc && (ofs == DDB_OFS_DATA);

  assign flush = flr_assert_q | (ctrl_wr & cfg_wdata[CTRL_CLR_BIT]);
  assign push  = en_q & ~fifo_full & ~flush;
  assign pop   = data_rd & ~fifo_empty & ~flush;

  assign count16 = {{(16-CW){1'b0}}, fifo_count};

  always_comb begin
    status                 = '0;
    status[15:0]           = count16;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_UNF_BIT]   = unf_q;
  end

  always_comb begin
    ack_d     = wr_acc | rd_acc;
    rdata_d   = rdata_q;
    en_d      = en_q;
    thresh_d  = thresh_q;
    seed_d    = seed_q;
    unf_d     = unf_q;
    gen_d     = gen_q;
    gen_cnt_d = gen_cnt_q;

    if (rd_acc) begin
      case (ofs)
        DDB_OFS_CTRL:    rdata_d = {16'h0, thresh_q, 7'h0, en_q};
        DDB_OFS_STATUS:  rdata_d = status;
        DDB_OFS_DATA:    rdata_d = fifo_empty ? DDB_DEADBEEF : fifo_head;
        DDB_OFS_SEED:    rdata_d = seed_q;
        DDB_OFS_GEN_CNT: rdata_d = gen_cnt_q;
        default:         rdata_d = DDB_DEADBEEF;
      endcase
    end

    if (ctrl_wr) begin
      en_d     = cfg_wdata[CTRL_EN_BIT];
      thresh_d = cfg_wdata[CTRL_THR_MSB:CTRL_THR_LSB];
      if (cfg_wdata[CTRL_UNF_CLR_BIT]) unf_d = 1'b0;
    end
    if (seed_wr) seed_d = cfg_wdata;
    // Underflow is applied after the clear so a coincident set wins.
    if (data_rd && fifo_empty) unf_d = 1'b1;

    if (push) begin
      gen_d     = gen_step(gen_q);
      gen_cnt_d = gen_cnt_q + 32'd1;
    end
    if (flush) begin
      gen_d     = gen_load(seed_q);
      gen_cnt_d = '0;
    end
    if (flr_assert_q) begin
      en_d     = 1'b0;
      thresh_d = '0;
      unf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      en_q      <= 1'b0;
      thresh_q  <= '0;
      seed_q    <= GEN_INIT;
      unf_q     <= 1'b0;
      gen_q     <= GEN_INIT;
      gen_cnt_q <= '0;
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      thresh_q  <= thresh_d;
      seed_q    <= seed_d;
      unf_q     <= unf_d;
      gen_q     <= gen_d;
      gen_cnt_q <= gen_cnt_d;
    end
  end

  ddb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (sync_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (gen_q),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cfg_ack     = ack_q;
  assign cfg_rdata   = rdata_q;
  assign ddb_irq_lvl = en_q && (count16 >= {8'h0, thresh_q});

endmodule

// File: tb/tb_cl_ddb_cfg_slv.sv
// Self-checking bench for cl_ddb_cfg_slv: every access queues its expected ack cycle and read data,
// and a negedge monitor retires entries as cfg_ack pulses arrive.
module tb_cl_ddb_cfg_slv;

  localparam logic [31:0] DEADBEEF = 32'hdead_beef;
  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_DATA = 32'h08;
  localparam logic [31:0] A_SEED = 32'h0C, A_GCNT = 32'h10;

  logic        clk = 1'b0;
  logic        sync_rst_n = 1'b0;
  logic        flr_assert_q = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_wr = 1'b0;
  logic        cfg_rd = 1'b0;
  logic        cfg_ack;
  logic [31:0] cfg_rdata;
  logic        ddb_irq_lvl;

  cl_ddb_cfg_slv #(.FIFO_DEPTH(16), .GEN_INIT(32'h0000_0001)) dut (
    .clk          (clk),
    .sync_rst_n   (sync_rst_n),
    .flr_assert_q (flr_assert_q),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_wr       (cfg_wr),
    .cfg_rd       (cfg_rd),
    .cfg_ack      (cfg_ack),
    .cfg_rdata    (cfg_rdata),
    .ddb_irq_lvl  (ddb_irq_lvl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          chk;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] g);
`ifdef DDB_LFSR_EN
    return (g >> 1) ^ (g[0] ? 32'h8020_0003 : 32'h0);
`else
    return g + 32'd1;
`endif
  endfunction

  always @(negedge clk) begin
    if (cfg_ack) begin
      if (sbq.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.tag, "_ack_cycle"}, cyc, mon_e.due);
        if (mon_e.chk) check(mon_e.tag, cfg_rdata, mon_e.exp);
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      check({mon_e.tag, "_no_ack"}, 32'd0, 32'd1);
    end
  end

  // Drivers are entered #1 after a rising edge and return #1 after the next one.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wr    = 1'b1;
    sbq.push_back('{cyc + 1, 1'b0, 32'h0, "wr"});
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    cfg_addr = a;
    cfg_rd   = 1'b1;
    sbq.push_back('{cyc + 1, 1'b1, exp, tag});
    @(posedge clk); #1;
    cfg_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  logic [31:0] v;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, cfg_ack}, 32'd0);
    check("rst_rdata", cfg_rdata, 32'd0);
    check("rst_irq", {31'h0, ddb_irq_lvl}, 32'd0);
    sync_rst_n = 1'b1;
    idle(1);

    rd(A_STAT, 32'h0001_0000, "status_rst");
    rd(32'h44, DEADBEEF, "unmapped_rd");
    rd(A_CTRL, 32'h0, "ctrl_rst");
    rd(A_SEED, 32'h1, "seed_rst");
    rd(A_GCNT, 32'h0, "gencnt_rst");
    rd(32'h0000_1004, 32'h0001_0000, "status_alias");
    wr(32'h48, 32'h1234_5678);
    rd(A_SEED, 32'h1, "seed_after_unmapped_wr");

    // Fill to full from SEED=5, then drain in order.
    wr(A_SEED, 32'd5);
    wr(A_CTRL, 32'h3);
    idle(20);
    wr(A_CTRL, 32'h0);
    rd(A_STAT, 32'h0002_0010, "status_full");
    rd(A_GCNT, 32'd16, "gencnt_full");
    v = 32'd5;
    for (int i = 0; i < 16; i++) begin
      rd(A_DATA, v, "data_fill");
      v = m_step(v);
    end
    rd(A_STAT, 32'h0001_0000, "status_drained");
    rd(A_DATA, DEADBEEF, "data_underflow");
    rd(A_STAT, 32'h8001_0000, "status_unf");
    wr(A_CTRL, 32'h4);
    rd(A_STAT, 32'h0001_0000, "status_unf_clr");
    rd(A_CTRL, 32'h0, "ctrl_self_clear");

    // Threshold interrupt: thresh=4, generator continuing from where it stopped.
    wr(A_CTRL, 32'h0000_0401);
    check("irq_at_0", {31'h0, ddb_irq_lvl}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check("irq_ramp", {31'h0, ddb_irq_lvl}, (k >= 4) ? 32'd1 : 32'd0);
    end
    wr(A_CTRL, 32'h0000_0400);
    check("irq_en_off", {31'h0, ddb_irq_lvl}, 32'd0);
    rd(A_STAT, 32'h0000_0005, "status_irq_stop");
    rd(A_DATA, v, "data_irq0");
    v = m_step(v);
    rd(A_DATA, v, "data_irq1");
    v = m_step(v);
    rd(A_STAT, 32'h0000_0003, "status_pop3");
    check("irq_count3", {31'h0, ddb_irq_lvl}, 32'd0);

    // Back-to-back DATA reads while the generator runs.
    wr(A_CTRL, 32'h3);
    idle(3);
    v = 32'd5;
    for (int i = 0; i < 10; i++) begin
      rd(A_DATA, v, "data_b2b");
      v = m_step(v);
    end
    wr(A_CTRL, 32'h0);
    rd(A_GCNT, 32'd14, "gencnt_b2b");
    rd(A_STAT, 32'h0000_0004, "status_b2b");
    for (int i = 0; i < 4; i++) begin
      rd(A_DATA, v, "data_b2b_tail");
      v = m_step(v);
    end
    rd(A_STAT, 32'h0001_0000, "status_b2b_empty");

    // Simultaneous rd+wr: the write wins and exactly one ack comes back.
    cfg_addr  = A_SEED;
    cfg_wdata = 32'h77;
    cfg_wr    = 1'b1;
    cfg_rd    = 1'b1;
    sbq.push_back('{cyc + 1, 1'b0, 32'h0, "rdwr"});
    idle(1);
    cfg_wr = 1'b0;
    cfg_rd = 1'b0;
    rd(A_SEED, 32'h77, "seed_rdwr");

    // FLR mid-fill with UNF set beforehand.
    rd(A_DATA, DEADBEEF, "data_underflow2");
    wr(A_CTRL, 32'h0000_0203);
    idle(5);
    flr_assert_q = 1'b1;
    cfg_addr     = A_DATA;
    cfg_rd       = 1'b1;
    idle(1);
    cfg_rd = 1'b0;
    idle(1);
    flr_assert_q = 1'b0;
    check("flr_no_ack", {31'h0, cfg_ack}, 32'd0);
    rd(A_CTRL, 32'h0, "ctrl_flr");
    rd(A_STAT, 32'h0001_0000, "status_flr");
    rd(A_GCNT, 32'h0, "gencnt_flr");
    idle(3);
    rd(A_STAT, 32'h0001_0000, "status_flr_idle");
    wr(A_CTRL, 32'h1);
    idle(2);
    rd(A_DATA, 32'h77, "data_after_flr");
    wr(A_CTRL, 32'h2);

`ifdef DDB_LFSR_EN
    wr(A_SEED, 32'h0);
    wr(A_CTRL, 32'h3);
    idle(2);
    rd(A_DATA, 32'h0000_0001, "lfsr_first");
    rd(A_DATA, 32'h8020_0003, "lfsr_second");
    wr(A_CTRL, 32'h2);
`endif

    // Asynchronous reset while an ack is on the bus.
    wr(A_SEED, 32'h55);
    wr(A_CTRL, 32'h0000_0101);
    idle(2);
    check("irq_pre_rst", {31'h0, ddb_irq_lvl}, 32'd1);
    cfg_addr = A_STAT;
    cfg_rd   = 1'b1;
    idle(1);
    cfg_rd = 1'b0;
    check("ack_pre_rst", {31'h0, cfg_ack}, 32'd1);
    sync_rst_n = 1'b0;
    #1;
    check("rst_mid_ack", {31'h0, cfg_ack}, 32'd0);
    check("rst_mid_rdata", cfg_rdata, 32'd0);
    check("rst_mid_irq", {31'h0, ddb_irq_lvl}, 32'd0);
    #10;
    sync_rst_n = 1'b1;
    idle(1);
    rd(A_SEED, 32'h1, "seed_after_rst");
    rd(A_CTRL, 32'h0, "ctrl_after_rst");
    rd(A_STAT, 32'h0001_0000, "status_after_rst");
    rd(A_GCNT, 32'h0, "gencnt_after_rst");

    idle(2);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
